// File: rtl/reg_operand_sequencer.sv
// Multi-channel operand register sequencer: reads operands (optionally through a
// pointer register) and writes results back with post-increment/decrement over one bus.
module reg_operand_sequencer #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int CH  = 4,
  parameter int RNW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     base_addr,
  input  logic              start,
  input  logic              op,
  input  logic [CH-1:0]     ch_valid,
  input  logic [CH*RNW-1:0] ch_regnum,
  input  logic [CH-1:0]     ch_is_ptr,
  input  logic [CH*2-1:0]   ch_flags,
  input  logic [CH-1:0]     ch_save,
  input  logic [CH*DW-1:0]  wr_data,
  output logic              busy,
  output logic              done,
  output logic [CH*DW-1:0]  ch_value,
  output logic [CH*DW-1:0]  ch_ptr,
  output logic              bus_req,
  output logic              bus_we,
  output logic [AW-1:0]     bus_addr,
  output logic [DW-1:0]     bus_wdata,
  input  logic              bus_ack,
  input  logic [DW-1:0]     bus_rdata
);

  localparam int IW = (CH > 1) ? $clog2(CH) : 1;

  typedef enum logic [2:0] {
    IDLE, RD_REG, RD_PTR, WR_DATA, WR_PTR, NEXT, FIN
  } state_t;

  state_t state, state_nxt;

  // Request context captured at start
  logic                     op_q;
  logic [AW-1:0]            base_q;
  logic [CH-1:0]            sel_q;
  logic [CH-1:0]            is_ptr_q;
  logic [CH-1:0][RNW-1:0]   regnum_q;
  logic [CH-1:0][1:0]       flags_q;
  logic [CH-1:0][DW-1:0]    wr_data_q;

  // Per-channel results, visible on the outputs
  logic [CH-1:0][DW-1:0]    value_q;
  logic [CH-1:0][DW-1:0]    ptr_q;

  // Channel in flight and a pending second access for it
  logic [IW-1:0]            cur_q;
  logic                     follow_q;
  logic [AW-1:0]            follow_addr_q;
  logic [DW-1:0]            follow_wdata_q;

  logic                     ack_hit;
  logic                     any_sel;
  logic [IW-1:0]            nxt_idx;
  logic [AW-1:0]            reg_addr_nxt;
  logic [AW-1:0]            data_addr_nxt;
  logic [DW-1:0]            adj_nxt;
  logic [AW-1:0]            reg_addr_cur;
  logic [DW-1:0]            ptr_step_cur;

  function automatic logic [DW-1:0] adjust(input logic [DW-1:0] v, input logic [1:0] f);
    case (f)
      2'b01:   adjust = v + DW'(1);
      2'b10:   adjust = v - DW'(1);
      default: adjust = v;
    endcase
  endfunction

  assign ack_hit  = bus_req && bus_ack;
  assign busy     = (state != IDLE) && (state != FIN);
  assign done     = (state == FIN);
  assign ch_value = value_q;
  assign ch_ptr   = ptr_q;

  // Lowest remaining selected channel; lets NEXT skip unselected ones in zero cycles.
  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    nxt_idx = '0;
    any_sel = 1'b0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (sel_q[i]) begin
        nxt_idx = IW'(i);
        any_sel = 1'b1;
      end
    end
  end

  assign reg_addr_nxt  = base_q + AW'(regnum_q[nxt_idx]);
  assign data_addr_nxt = base_q + ptr_q[nxt_idx][AW-1:0];
  assign adj_nxt       = adjust(wr_data_q[nxt_idx], flags_q[nxt_idx]);
  assign reg_addr_cur  = base_q + AW'(regnum_q[cur_q]);
  assign ptr_step_cur  = adjust(ptr_q[cur_q], flags_q[cur_q]);

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = NEXT;
      NEXT: begin
        if (follow_q)     state_nxt = op_q ? WR_PTR : RD_PTR;
        else if (any_sel) state_nxt = op_q ? WR_DATA : RD_REG;
        else              state_nxt = FIN;
      end
      RD_REG, RD_PTR, WR_DATA, WR_PTR: if (ack_hit) state_nxt = NEXT;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Every access returns through NEXT, which guarantees an idle request cycle between accesses.
  // NOTE: the per-channel value/pointer arrays are reset because they drive outputs that must read 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q           <= 1'b0;
      base_q         <= '0;
      sel_q          <= '0;
      is_ptr_q       <= '0;
      regnum_q       <= '0;
      flags_q        <= '0;
      wr_data_q      <= '0;
      value_q        <= '0;
      ptr_q          <= '0;
      cur_q          <= '0;
      follow_q       <= 1'b0;
      follow_addr_q  <= '0;
      follow_wdata_q <= '0;
      bus_req        <= 1'b0;
      bus_we         <= 1'b0;
      bus_addr       <= '0;
      bus_wdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q      <= op;
            base_q    <= base_addr;
            sel_q     <= op ? (ch_valid & ch_save) : ch_valid;
            is_ptr_q  <= ch_is_ptr;
            regnum_q  <= ch_regnum;
            flags_q   <= ch_flags;
            wr_data_q <= wr_data;
            follow_q  <= 1'b0;
          end
        end
        NEXT: begin
          if (follow_q) begin
            bus_req   <= 1'b1;
            bus_we    <= op_q;
            bus_addr  <= follow_addr_q;
            bus_wdata <= follow_wdata_q;
            follow_q  <= 1'b0;
          end else if (any_sel) begin
            cur_q          <= nxt_idx;
            sel_q[nxt_idx] <= 1'b0;
            bus_req        <= 1'b1;
            bus_we         <= op_q;
            if (op_q && is_ptr_q[nxt_idx]) begin
              bus_addr  <= data_addr_nxt;
              bus_wdata <= wr_data_q[nxt_idx];
            end else if (op_q) begin
              bus_addr  <= reg_addr_nxt;
              bus_wdata <= adj_nxt;
            end else begin
              bus_addr  <= reg_addr_nxt;
              bus_wdata <= '0;
            end
          end
        end
        RD_REG: begin
          if (ack_hit) begin
            bus_req       <= 1'b0;
            ptr_q[cur_q]  <= bus_rdata;
            if (is_ptr_q[cur_q]) begin
              follow_q      <= 1'b1;
              follow_addr_q <= base_q + bus_rdata[AW-1:0];
            end else begin
              value_q[cur_q] <= bus_rdata;
            end
          end
        end
        RD_PTR: begin
          if (ack_hit) begin
            bus_req        <= 1'b0;
            value_q[cur_q] <= bus_rdata;
          end
        end
        WR_DATA: begin
          if (ack_hit) begin
            bus_req <= 1'b0;
            // Pointer channels with a step flag must also update the pointer register
            if (is_ptr_q[cur_q] && (^flags_q[cur_q])) begin
              follow_q       <= 1'b1;
              follow_addr_q  <= reg_addr_cur;
              follow_wdata_q <= ptr_step_cur;
            end
          end
        end
        WR_PTR: begin
          if (ack_hit) begin
            bus_req      <= 1'b0;
            ptr_q[cur_q] <= bus_wdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_operand_sequencer.sv
// Directed bench for reg_operand_sequencer: a vector table of single operations
// against a memory responder, plus hand-written reset/timing/handshake corner cases.
module tb_reg_operand_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  base_addr;
  logic         start;
  logic         op;
  logic [3:0]   ch_valid;
  logic [15:0]  ch_regnum;
  logic [3:0]   ch_is_ptr;
  logic [7:0]   ch_flags;
  logic [3:0]   ch_save;
  logic [127:0] wr_data;
  logic         busy;
  logic         done;
  logic [127:0] ch_value;
  logic [127:0] ch_ptr;
  logic         bus_req;
  logic         bus_we;
  logic [31:0]  bus_addr;
  logic [31:0]  bus_wdata;
  logic         bus_ack;
  logic [31:0]  bus_rdata;

  logic         resp_ack;
  logic         stray_ack;
  assign bus_ack = resp_ack | stray_ack;

  always #5 clk = ~clk;

  reg_operand_sequencer #(.AW(32), .DW(32), .CH(4), .RNW(4)) dut (
    .clk(clk), .rst(rst), .base_addr(base_addr), .start(start), .op(op),
    .ch_valid(ch_valid), .ch_regnum(ch_regnum), .ch_is_ptr(ch_is_ptr),
    .ch_flags(ch_flags), .ch_save(ch_save), .wr_data(wr_data),
    .busy(busy), .done(done), .ch_value(ch_value), .ch_ptr(ch_ptr),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  // Memory responder: acks each request on its second cycle and logs the access
  logic [31:0] mem [logic [31:0]];
  logic        log_we   [256];
  logic [31:0] log_addr [256];
  logic [31:0] log_data [256];
  int          log_n;

  initial begin
    int wait_cnt;
    mem[32'h103] = 32'hDEAD;
    mem[32'h105] = 32'h20;
    mem[32'h120] = 32'h77;
    mem[32'h109] = 32'h99;
    mem[32'h10A] = 32'h0;
    mem[32'h100] = 32'h55;
    resp_ack  = 1'b0;
    bus_rdata = '0;
    log_n     = 0;
    wait_cnt  = 0;
    forever begin
      @(posedge clk); #1;
      if (resp_ack) begin
        resp_ack = 1'b0;
        wait_cnt = 0;
      end else if (bus_req) begin
        wait_cnt++;
        if (wait_cnt >= 2) begin
          if (bus_we) begin
            mem[bus_addr] = bus_wdata;
            if (log_n < 256) log_data[log_n] = bus_wdata;
          end else begin
            bus_rdata = mem.exists(bus_addr) ? mem[bus_addr] : 32'h0;
            if (log_n < 256) log_data[log_n] = bus_rdata;
          end
          if (log_n < 256) begin
            log_we[log_n]   = bus_we;
            log_addr[log_n] = bus_addr;
          end
          log_n++;
          resp_ack = 1'b1;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    string            name;
    logic             op;
    logic [31:0]      base;
    logic [3:0]       valid;
    logic [15:0]      regnum;
    logic [3:0]       is_ptr;
    logic [7:0]       flags;
    logic [3:0]       save;
    logic [127:0]     wdata;
    int               n_acc;
    logic [1:0]       exp_we;
    logic [1:0][31:0] exp_addr;
    logic [1:0][31:0] exp_data;
    int               chk_ch;
    logic [31:0]      exp_value;
    logic [31:0]      exp_ptr;
  } vec_t;

  vec_t vecs[10];

  task automatic drive(input logic o, input logic [31:0] b, input logic [3:0] v,
                       input logic [15:0] r, input logic [3:0] p, input logic [7:0] f,
                       input logic [3:0] s, input logic [127:0] w);
    op = o; base_addr = b; ch_valid = v; ch_regnum = r;
    ch_is_ptr = p; ch_flags = f; ch_save = s; wr_data = w;
  endtask

  // Pulses start and waits (bounded) for done; returns the number of done pulses seen
  task automatic run_op(output int n_done);
    int cyc;
    n_done = 0;
    cyc    = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (n_done == 0 && cyc < 200) begin
      if (done) n_done++;
      else @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    if (done) n_done++;
  endtask

  task automatic run_vec(input int i);
    int snap, nd;
    drive(vecs[i].op, vecs[i].base, vecs[i].valid, vecs[i].regnum,
          vecs[i].is_ptr, vecs[i].flags, vecs[i].save, vecs[i].wdata);
    snap = log_n;
    run_op(nd);
    check({vecs[i].name, ".done_count"}, 128'(nd), 128'd1);
    check({vecs[i].name, ".busy_after"}, 128'(busy), 128'd0);
    check({vecs[i].name, ".n_access"}, 128'(log_n - snap), 128'(vecs[i].n_acc));
    for (int k = 0; k < vecs[i].n_acc && k < 2; k++) begin
      check($sformatf("%s.acc%0d_we", vecs[i].name, k), 128'(log_we[snap+k]), 128'(vecs[i].exp_we[k]));
      check($sformatf("%s.acc%0d_addr", vecs[i].name, k), 128'(log_addr[snap+k]), 128'(vecs[i].exp_addr[k]));
      check($sformatf("%s.acc%0d_data", vecs[i].name, k), 128'(log_data[snap+k]), 128'(vecs[i].exp_data[k]));
    end
    check({vecs[i].name, ".ch_value"}, 128'(ch_value[vecs[i].chk_ch*32 +: 32]), 128'(vecs[i].exp_value));
    check({vecs[i].name, ".ch_ptr"}, 128'(ch_ptr[vecs[i].chk_ch*32 +: 32]), 128'(vecs[i].exp_ptr));
  endtask

  initial begin
    int snap, nd, cyc;
    logic req_seen;

    //             name               op    base     valid    regnum    isptr    flags         save     wdata
    //             n  we     addr{2nd,1st}            data{2nd,1st}                   ch value          ptr
    vecs[0] = '{"rd_noptr",        1'b0, 32'h100, 4'b0001, 16'h0003, 4'b0000, 8'b00000000, 4'b0000, 128'h0,
                1, 2'b00, {32'h0, 32'h103},       {32'h0, 32'hDEAD},            0, 32'hDEAD,     32'hDEAD};
    vecs[1] = '{"rd_ptr",          1'b0, 32'h100, 4'b0010, 16'h0050, 4'b0010, 8'b00000000, 4'b0000, 128'h0,
                2, 2'b00, {32'h120, 32'h105},     {32'h77, 32'h20},             1, 32'h77,       32'h20};
    vecs[2] = '{"wb_ptr_inc",      1'b1, 32'h100, 4'b0010, 16'h0050, 4'b0010, 8'b00000100, 4'b0010,
                {32'h0, 32'h0, 32'hAB, 32'h0},
                2, 2'b11, {32'h105, 32'h120},     {32'h21, 32'hAB},             1, 32'h77,       32'h21};
    vecs[3] = '{"wb_dec_wrap",     1'b1, 32'h100, 4'b0100, 16'h0700, 4'b0000, 8'b00100000, 4'b0100, 128'h0,
                1, 2'b01, {32'h0, 32'h107},       {32'h0, 32'hFFFFFFFF},        2, 32'h0,        32'h0};
    vecs[4] = '{"rd_multi",        1'b0, 32'h100, 4'b1010, 16'h9050, 4'b0000, 8'b00000000, 4'b0000, 128'h0,
                2, 2'b00, {32'h109, 32'h105},     {32'h99, 32'h21},             3, 32'h99,       32'h99};
    vecs[5] = '{"rd_ptr_zero",     1'b0, 32'h100, 4'b0001, 16'h000A, 4'b0001, 8'b00000000, 4'b0000, 128'h0,
                2, 2'b00, {32'h100, 32'h10A},     {32'h55, 32'h0},              0, 32'h55,       32'h0};
    vecs[6] = '{"wb_ptr_dec_wrap", 1'b1, 32'h100, 4'b0001, 16'h000A, 4'b0001, 8'b00000010, 4'b0001,
                {96'h0, 32'h11},
                2, 2'b11, {32'h10A, 32'h100},     {32'hFFFFFFFF, 32'h11},       0, 32'h55,       32'hFFFFFFFF};
    vecs[7] = '{"wb_inc_wrap",     1'b1, 32'h100, 4'b1000, 16'h9000, 4'b0000, 8'b01000000, 4'b1000,
                {32'hFFFFFFFF, 96'h0},
                1, 2'b01, {32'h0, 32'h109},       {32'h0, 32'h0},               3, 32'h99,       32'h99};
    vecs[8] = '{"wb_ptr_noflag",   1'b1, 32'h100, 4'b0001, 16'h000A, 4'b0001, 8'b00000011, 4'b0001,
                {96'h0, 32'h33},
                1, 2'b01, {32'h0, 32'hFF},        {32'h0, 32'h33},              0, 32'h55,       32'hFFFFFFFF};
    vecs[9] = '{"wb_no_save",      1'b1, 32'h100, 4'b1111, 16'h1234, 4'b0000, 8'b01010101, 4'b0000, 128'h0,
                0, 2'b00, {32'h0, 32'h0},         {32'h0, 32'h0},               0, 32'h55,       32'hFFFFFFFF};

    rst = 1'b1;
    start = 1'b0;
    stray_ack = 1'b0;
    drive(1'b0, 32'h0, 4'b0, 16'h0, 4'b0, 8'h0, 4'b0, 128'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("reset.busy", 128'(busy), 128'd0);
    check("reset.done", 128'(done), 128'd0);
    check("reset.bus_req", 128'(bus_req), 128'd0);
    check("reset.bus_we", 128'(bus_we), 128'd0);
    check("reset.bus_addr", 128'(bus_addr), 128'd0);
    check("reset.ch_value", ch_value, 128'd0);
    check("reset.ch_ptr", ch_ptr, 128'd0);

    // Empty selection: busy in the first cycle after start, done in the second
    drive(1'b0, 32'h100, 4'b0000, 16'h0, 4'b0, 8'h0, 4'b0, 128'h0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("empty.c1_busy", 128'(busy), 128'd1);
    check("empty.c1_done", 128'(done), 128'd0);
    req_seen = bus_req;
    @(negedge clk);
    check("empty.c2_done", 128'(done), 128'd1);
    check("empty.c2_busy", 128'(busy), 128'd0);
    req_seen = req_seen | bus_req;
    @(negedge clk);
    check("empty.c3_done", 128'(done), 128'd0);
    check("empty.no_req", 128'(req_seen | bus_req), 128'd0);

    // Stray ack while idle changes nothing
    snap = log_n;
    stray_ack = 1'b1;
    @(negedge clk); stray_ack = 1'b0;
    @(negedge clk);
    check("stray.busy", 128'(busy), 128'd0);
    check("stray.done", 128'(done), 128'd0);
    check("stray.bus_req", 128'(bus_req), 128'd0);
    check("stray.no_access", 128'(log_n - snap), 128'd0);

    for (int i = 0; i < 10; i++) run_vec(i);

    // Start pulsed while busy is ignored
    drive(1'b0, 32'h100, 4'b0001, 16'h0003, 4'b0, 8'h0, 4'b0, 128'h0);
    snap = log_n;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    drive(1'b1, 32'h200, 4'b1111, 16'h4444, 4'b0, 8'h55, 4'b1111, {4{32'h5A5A5A5A}});
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    nd = 0;
    cyc = 0;
    while (cyc < 40) begin
      if (done) nd++;
      @(negedge clk);
      cyc++;
    end
    check("busy_start.done_count", 128'(nd), 128'd1);
    check("busy_start.n_access", 128'(log_n - snap), 128'd1);
    check("busy_start.addr", 128'(log_addr[snap]), 128'h103);
    check("busy_start.we", 128'(log_we[snap]), 128'd0);
    check("busy_start.ch_value0", 128'(ch_value[31:0]), 128'hDEAD);

    // Reset while RD_PTR has its request up
    drive(1'b0, 32'h100, 4'b0010, 16'h0050, 4'b0010, 8'h0, 4'b0, 128'h0);
    snap = log_n;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!(bus_req && (log_n - snap) == 1) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_mid.reached_rd_ptr", 128'(bus_req && (log_n - snap) == 1), 128'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid.bus_req", 128'(bus_req), 128'd0);
    check("rst_mid.busy", 128'(busy), 128'd0);
    check("rst_mid.ch_value", ch_value, 128'd0);
    check("rst_mid.ch_ptr", ch_ptr, 128'd0);
    check("rst_mid.done", 128'(done), 128'd0);
    rst = 1'b0;
    nd = 0;
    req_seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) nd++;
      req_seen = req_seen | bus_req;
    end
    check("rst_mid.no_done", 128'(nd), 128'd0);
    check("rst_mid.no_req", 128'(req_seen), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
